rst_run_ctrl: RTL and testbench
===============================

Name: rst_run_ctrl

Overview:
Synthesizable reset and run-control block that sits between the external reset pin and the min_sopc core. It turns a raw asynchronous reset into a synchronised, stretched core reset. After reset it counts core run cycles and freezes the core on timeout or on an explicit halt request, reporting how and when the run ended. It is the in-hardware counterpart of the bench's reset/stop sequencing.

Parameters:
SYNC_STAGES, 2, depth of the reset-release synchroniser chain (>=2)
HOLD_CYCLES, 10, extra cycles the core reset stays high after synchronised release; 0 = no hold
RUN_CYCLES, 50, run cycles before automatic halt; 0 = unlimited
CNT_WIDTH, 32, width of cycle_cnt

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  external reset, asynchronous, active-high
halt_req  input  1  halt request from core/peripheral, sampled only in RUN
cpu_rst  output  1  reset to the core, active-high; asserts asynchronously, deasserts synchronously
run  output  1  high while the core is executing
done  output  1  sticky end-of-run flag
halt_cause  output  2  0 none, 1 timeout, 2 halt_req
cycle_cnt  output  CNT_WIDTH  number of completed RUN cycles

Behaviour:
- rst=1, asynchronous, regardless of clk:
  - all synchroniser stages = 1
  - state = RESET
  - cpu_rst=1, run=0, done=0, halt_cause=0, cycle_cnt=0, hold counter=0
- Synchroniser:
  - each edge shifts 0 into stage 0; rst_sync = last stage.
  - Edges are numbered E1, E2, … from the first edge with rst=0.
  - rst_sync falls at edge E_SYNC_STAGES.
- States: RESET, HOLD, RUN, DONE. All outputs are registered and change together with the state.
- RESET:
  - if rst_sync=0 at an edge: go to HOLD with hold counter=0.
  - If HOLD_CYCLES=0, go straight to RUN (cpu_rst<=0, run<=1).
- HOLD:
  - hold counter increments each edge.
  - At the edge where hold counter == HOLD_CYCLES-1: go to RUN, cpu_rst<=0, run<=1.
  - With defaults, cpu_rst falls at edge E13.
- RUN:
  - cycle_cnt <= cycle_cnt+1 each edge, saturating at all-ones.
  - If halt_req=1 at an edge: go to DONE, halt_cause<=2. That cycle is still counted.
  - Else if RUN_CYCLES!=0 and cycle_cnt==RUN_CYCLES-1: go to DONE, halt_cause<=1.
  - halt_req and timeout on the same edge: halt_req wins, halt_cause=2.
- DONE:
  - cpu_rst=1, run=0, done=1; cycle_cnt and halt_cause frozen.
  - Sticky until rst; halt_req ignored.
- halt_req is ignored in RESET and HOLD.
- Reset mid-operation (any state):
  - immediate asynchronous return to RESET values, then the full sync + hold sequence.
  - A rst pulse shorter than one clock period still resets fully.
- Invariants:
  - cpu_rst = !run at all times.
  - done=1 implies halt_cause != 0.

Test Plan:
- Defaults, rst high 195 ns then low, clk 20 ns -> cpu_rst falls exactly 13 edges after first low-rst edge; run=1 at the same edge.
- Defaults, no halt_req -> after 50 RUN edges: done=1, halt_cause=1, cycle_cnt=50, cpu_rst=1; all values hold for 100 further cycles.
- halt_req pulsed one cycle on the 7th RUN edge -> done=1, halt_cause=2, cycle_cnt=7; a later halt_req has no effect.
- halt_req asserted on the 50th RUN edge (coincident with timeout) -> halt_cause=2, cycle_cnt=50.
- rst pulsed 3 ns mid-RUN at cycle_cnt=20 -> outputs clear asynchronously within the pulse, without waiting for an edge; the sequence restarts and cpu_rst falls 13 edges later; cycle_cnt restarts from 0.
- HOLD_CYCLES=0, RUN_CYCLES=0, CNT_WIDTH=4 -> run=1 at edge E3 (SYNC_STAGES+1); cycle_cnt saturates at 15; done stays 0 until halt_req, then halt_cause=2.

Source files
------------

// File: rtl/rst_run_ctrl.sv
// Reset and run controller for the min_sopc core.
// Synchronises and stretches the external reset, then times the run and freezes the core at the end.
module rst_run_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 10,
   parameter int RUN_CYCLES  = 50,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 halt_req,
   output logic                 cpu_rst,
   output logic                 run,
   output logic                 done,
   output logic [1:0]           halt_cause,
   output logic [CNT_WIDTH-1:0] cycle_cnt
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);
   localparam logic [CNT_WIDTH-1:0] RUN_LAST  = CNT_WIDTH'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;
   localparam logic [1:0] CAUSE_HALT    = 2'd2;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_HOLD  = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   rst_sync;
   logic [HOLD_W-1:0]      hold_cnt_q;
   logic [CNT_WIDTH-1:0]   cycle_cnt_q;
   logic [CNT_WIDTH-1:0]   cycle_cnt_d;
   logic                   cpu_rst_q;
   logic                   run_q;
   logic                   done_q;
   logic [1:0]             halt_cause_q;

   // Release ripples through the chain: zeros enter at stage 0, last stage is the synced reset.
   assign sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b0};
   assign rst_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign cycle_cnt_d = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + CNT_ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_RESET;
         hold_cnt_q   <= '0;
         cycle_cnt_q  <= '0;
         cpu_rst_q    <= 1'b1;
         run_q        <= 1'b0;
         done_q       <= 1'b0;
         halt_cause_q <= CAUSE_NONE;
      end else begin
         case (state_q)
            S_RESET: begin
               if (!rst_sync) begin
                  hold_cnt_q <= '0;
                  if (HOLD_CYCLES == 0) begin
                     state_q   <= S_RUN;
                     cpu_rst_q <= 1'b0;
                     run_q     <= 1'b1;
                  end else begin
                     state_q <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_q   <= S_RUN;
                  cpu_rst_q <= 1'b0;
                  run_q     <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HOLD_ONE;
               end
            end
            S_RUN: begin
               // The terminating edge is itself a completed run cycle.
               cycle_cnt_q <= cycle_cnt_d;
               if (halt_req) begin
                  state_q      <= S_DONE;
                  cpu_rst_q    <= 1'b1;
                  run_q        <= 1'b0;
                  done_q       <= 1'b1;
                  halt_cause_q <= CAUSE_HALT;
               end else if ((RUN_CYCLES != 0) && (cycle_cnt_q == RUN_LAST)) begin
                  state_q      <= S_DONE;
                  cpu_rst_q    <= 1'b1;
                  run_q        <= 1'b0;
                  done_q       <= 1'b1;
                  halt_cause_q <= CAUSE_TIMEOUT;
               end
            end
            default: begin
               state_q <= S_DONE;
            end
         endcase
      end
   end

   assign cpu_rst    = cpu_rst_q;
   assign run        = run_q;
   assign done       = done_q;
   assign halt_cause = halt_cause_q;
   assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_rst_run_ctrl.sv
// Directed bench for rst_run_ctrl: default build plus a no-hold, unlimited, 4-bit-counter build.
module tb_rst_run_ctrl;

   logic        clk;
   logic        rst;
   logic        halt_req;
   logic        cpu_rst;
   logic        run;
   logic        done;
   logic [1:0]  halt_cause;
   logic [31:0] cycle_cnt;

   logic        rst2;
   logic        halt_req2;
   logic        cpu_rst2;
   logic        run2;
   logic        done2;
   logic [1:0]  halt_cause2;
   logic [3:0]  cycle_cnt2;

   int checks   = 0;
   int failures = 0;

   // Packed view: {cpu_rst, run, done, halt_cause, cycle_cnt zero-extended to 32}
   logic [36:0] exp_q[$];

   localparam logic [36:0] RST_W = {1'b1, 1'b0, 1'b0, 2'd0, 32'd0};

   rst_run_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .halt_req   (halt_req),
      .cpu_rst    (cpu_rst),
      .run        (run),
      .done       (done),
      .halt_cause (halt_cause),
      .cycle_cnt  (cycle_cnt)
   );

   rst_run_ctrl #(
      .SYNC_STAGES (2),
      .HOLD_CYCLES (0),
      .RUN_CYCLES  (0),
      .CNT_WIDTH   (4)
   ) dut2 (
      .clk        (clk),
      .rst        (rst2),
      .halt_req   (halt_req2),
      .cpu_rst    (cpu_rst2),
      .run        (run2),
      .done       (done2),
      .halt_cause (halt_cause2),
      .cycle_cnt  (cycle_cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   function automatic logic [36:0] mk(input logic cr, input logic r, input logic d,
                                      input logic [1:0] hc, input int cnt);
      return {cr, r, d, hc, 32'(cnt)};
   endfunction

   function automatic logic [36:0] observe(input bit sel);
      if (sel) return {cpu_rst2, run2, done2, halt_cause2, 28'd0, cycle_cnt2};
      return {cpu_rst, run, done, halt_cause, cycle_cnt};
   endfunction

   task automatic check_pop(input string tag, input bit sel);
      logic [36:0] exp_w;
      logic [36:0] obs_w;
      obs_w = observe(sel);
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s observed=%h expected=<empty queue>", tag, obs_w);
      end else begin
         exp_w = exp_q.pop_front();
         assert (obs_w === exp_w) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_w, exp_w);
         end
      end
   endtask

   task automatic now_check(input string tag, input bit sel, input logic [36:0] exp_w);
      exp_q.push_back(exp_w);
      check_pop(tag, sel);
   endtask

   task automatic step(input string tag, input bit sel, input logic [36:0] exp_w);
      exp_q.push_back(exp_w);
      @(posedge clk);
      #1;
      check_pop(tag, sel);
   endtask

   // Default build: 2 sync edges + 1 edge into HOLD + 10 hold edges -> RUN at E13.
   task automatic start_seq(input string tag);
      for (int k = 1; k <= 13; k++) begin
         halt_req = 1'($urandom_range(0, 1));
         step(tag, 1'b0, (k < 13) ? RST_W : mk(1'b0, 1'b1, 1'b0, 2'd0, 0));
      end
      halt_req = 1'b0;
   endtask

   task automatic run_edges(input string tag, input int from, input int to);
      for (int n = from; n <= to; n++) begin
         step(tag, 1'b0, mk(1'b0, 1'b1, 1'b0, 2'd0, n));
      end
   endtask

   // 3 ns pulse, checked 1 ns in, well clear of any clock edge.
   task automatic pulse_rst(input string tag);
      rst = 1'b1;
      #1;
      now_check(tag, 1'b0, RST_W);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      halt_req  = 1'b0;
      rst2      = 1'b1;
      halt_req2 = 1'b0;

      #5;
      now_check("reset_main", 1'b0, RST_W);
      now_check("reset_alt", 1'b1, RST_W);
      #190;
      rst = 1'b0;

      start_seq("release");

      run_edges("timeout_run", 1, 49);
      step("timeout_edge", 1'b0, mk(1'b1, 1'b0, 1'b1, 2'd1, 50));
      for (int i = 0; i < 100; i++) begin
         halt_req = 1'($urandom_range(0, 1));
         step("timeout_hold", 1'b0, mk(1'b1, 1'b0, 1'b1, 2'd1, 50));
      end
      halt_req = 1'b0;

      pulse_rst("clear_done");
      start_seq("release2");
      run_edges("halt_run", 1, 6);
      halt_req = 1'b1;
      step("halt7", 1'b0, mk(1'b1, 1'b0, 1'b1, 2'd2, 7));
      halt_req = 1'b0;
      for (int i = 0; i < 3; i++) step("halt7_idle", 1'b0, mk(1'b1, 1'b0, 1'b1, 2'd2, 7));
      halt_req = 1'b1;
      for (int i = 0; i < 3; i++) step("halt7_again", 1'b0, mk(1'b1, 1'b0, 1'b1, 2'd2, 7));
      halt_req = 1'b0;

      pulse_rst("clear_halt");
      start_seq("release3");
      run_edges("coincide_run", 1, 49);
      halt_req = 1'b1;
      step("coincide", 1'b0, mk(1'b1, 1'b0, 1'b1, 2'd2, 50));
      halt_req = 1'b0;

      pulse_rst("clear_coincide");
      start_seq("release4");
      run_edges("mid_run", 1, 20);
      pulse_rst("mid_run_clear");
      start_seq("restart");
      run_edges("restart_run", 1, 2);

      rst2 = 1'b0;
      step("alt_e1", 1'b1, RST_W);
      step("alt_e2", 1'b1, RST_W);
      step("alt_e3", 1'b1, mk(1'b0, 1'b1, 1'b0, 2'd0, 0));
      for (int n = 1; n <= 15; n++) step("alt_count", 1'b1, mk(1'b0, 1'b1, 1'b0, 2'd0, n));
      for (int i = 0; i < 5; i++) step("alt_saturate", 1'b1, mk(1'b0, 1'b1, 1'b0, 2'd0, 15));
      halt_req2 = 1'b1;
      step("alt_halt", 1'b1, mk(1'b1, 1'b0, 1'b1, 2'd2, 15));
      halt_req2 = 1'b0;
      step("alt_done", 1'b1, mk(1'b1, 1'b0, 1'b1, 2'd2, 15));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
